pipe_tracker: RTL and testbench

Parametrised instruction-tracking pipeline for the RISC-V core: carries each in-flight instruction's control word, instruction bits, destination register and valid bit through STAGES registered stages, and resolves stalls, bubbles, flushes and forwarding selects centrally. It replaces the hard-wired fetch/decode/execute/memory/writeback control registers and the separate hazard logic with a single block whose depth and load latency are parameters. It sits between the controller (which drives the decode-stage inputs) and the datapath muxes (which consume the per-stage outputs and forward selects).

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_stage_reg.sv | 29 ++
 rtl/pipe_tracker.sv | 164 ++++++++++++++++
 tb/tb_pipe_tracker.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and types for the instruction-tracking pipeline.
// Contents: register-index width, the canonical NOP used for bubbles and
// the forward-select type, which is wide enough for the deepest legal pipe
// (8 stages).
package pipe_pkg;

  localparam int unsigned RIDX_W   = 5;
  localparam int unsigned FW_MAX_W = 3;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef logic [FW_MAX_W-1:0] fw_sel_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register.
// Ports:
//   clk, rst   clock, asynchronous active-low reset (loads BUBBLE)
//   hold       keep the current contents
//   clear      load BUBBLE; wins over hold
//   d, q       stage payload in/out (packed, W bits)
module pipe_stage_reg #(
  parameter int unsigned   W      = 1,
  parameter logic [W-1:0]  BUBBLE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= BUBBLE;
    end else if (clear) begin
      q <= BUBBLE;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_tracker.sv
// Instruction-tracking pipeline: carries {valid, instr, ctrl, rwe, ld} for
// every in-flight instruction through STAGES stages and resolves stalls,
// bubbles, flushes and forward selects centrally.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   in_valid/instr/ctrl/rwe/ld decode-stage inputs (stage 0)
//   redirect                   taken branch/jump resolved in stage 1
//   ext_stall                  external freeze of the whole pipe
//   stall                      hold PC and stage-0 input this cycle
//   st_valid/instr/ctrl/rwe    per-stage state, stage k in slice k
//   fw_sel1, fw_sel2           forward source for stage-1 rs1/rs2 (0 = regfile)
//   retire                     last stage valid and advancing
// Optional: define PIPE_TRACKER_PERF_EN to add perf_retired / perf_bubbles.
module pipe_tracker
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned CW         = 25,
  parameter int unsigned STAGES     = 4,
  parameter int unsigned LOAD_STAGE = 2,
  localparam int unsigned FW_W      = $clog2(STAGES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [XLEN-1:0]        in_instr,
  input  logic [CW-1:0]          in_ctrl,
  input  logic                   in_rwe,
  input  logic                   in_ld,
  input  logic                   redirect,
  input  logic                   ext_stall,
  output logic                   stall,
  output logic [STAGES-1:0]      st_valid,
  output logic [STAGES*XLEN-1:0] st_instr,
  output logic [STAGES*CW-1:0]   st_ctrl,
  output logic [STAGES-1:0]      st_rwe,
  output logic [FW_W-1:0]        fw_sel1,
  output logic [FW_W-1:0]        fw_sel2,
`ifdef PIPE_TRACKER_PERF_EN
  output logic [31:0]            perf_retired,
  output logic [31:0]            perf_bubbles,
`endif
  output logic                   retire
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [CW-1:0]   ctrl;
    logic            rwe;
    logic            ld;
  } stage_t;

  localparam stage_t BUBBLE = '{valid: 1'b0, instr: XLEN'(NOP_INSTR),
                                ctrl: '0, rwe: 1'b0, ld: 1'b0};

  stage_t              st_d [STAGES];
  stage_t              st_q [STAGES];
  logic [STAGES-1:0]   hold;
  logic [STAGES-1:0]   clear;
  logic                load_use;
  fw_sel_t             sel1;
  fw_sel_t             sel2;

  // Stage inputs: stage 0 takes the decode slot, every later stage its predecessor.
  // rwe/ld are qualified by valid on entry so no stage ever holds a stale enable.
  always_comb begin
    st_d[0] = {in_valid, in_instr, in_ctrl, in_rwe & in_valid, in_ld & in_valid};
    for (int k = 1; k < int'(STAGES); k++) begin
      st_d[k] = st_q[k-1];
    end
  end

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    pipe_stage_reg #(
      .W      ($bits(stage_t)),
      .BUBBLE (BUBBLE)
    ) u_reg (
      .clk   (clk),
      .rst   (rst),
      .hold  (hold[k]),
      .clear (clear[k]),
      .d     (st_d[k]),
      .q     (st_q[k])
    );
  end

  // Load-use: a load still ahead of the load-data mux whose rd is read in stage 0.
  always_comb begin
    load_use = 1'b0;
    for (int j = 1; j < int'(LOAD_STAGE); j++) begin
      if (st_q[j].valid && st_q[j].ld && st_q[j].rwe &&
          (st_q[j].instr[11:7] != RIDX_W'(0)) &&
          ((st_q[j].instr[11:7] == st_q[0].instr[19:15]) ||
           (st_q[j].instr[11:7] == st_q[0].instr[24:20]))) begin
        load_use = 1'b1;
      end
    end
    if (!st_q[0].valid) begin
      load_use = 1'b0;
    end
  end

  // Per-stage hold/clear in priority order: ext_stall, redirect, load-use.
  always_comb begin
    hold  = {STAGES{ext_stall}};
    clear = '0;
    if (!ext_stall) begin
      if (redirect) begin
        clear[0] = 1'b1;
        clear[1] = 1'b1;
      end else if (load_use) begin
        hold[0]  = 1'b1;
        clear[1] = 1'b1;
      end
    end
  end

  assign stall  = ext_stall | (load_use & ~redirect);
  assign retire = st_q[STAGES-1].valid & ~ext_stall;

  // Forward select: scan oldest to youngest so the youngest match is left last.
  always_comb begin
    sel1 = '0;
    sel2 = '0;
    for (int k = int'(STAGES) - 1; k >= 2; k--) begin
      if (st_q[k].valid && st_q[k].rwe && (st_q[k].instr[11:7] != RIDX_W'(0))) begin
        if (st_q[k].instr[11:7] == st_q[1].instr[19:15]) sel1 = FW_MAX_W'(k);
        if (st_q[k].instr[11:7] == st_q[1].instr[24:20]) sel2 = FW_MAX_W'(k);
      end
    end
  end

  assign fw_sel1 = FW_W'(sel1);
  assign fw_sel2 = FW_W'(sel2);

  // Flatten stage state onto the per-stage output buses.
  always_comb begin
    st_valid = '0;
    st_instr = '0;
    st_ctrl  = '0;
    st_rwe   = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      st_valid[k]              = st_q[k].valid;
      st_instr[k*XLEN +: XLEN] = st_q[k].instr;
      st_ctrl[k*CW +: CW]      = st_q[k].ctrl;
      st_rwe[k]                = st_q[k].valid & st_q[k].rwe;
    end
  end

`ifdef PIPE_TRACKER_PERF_EN
  // Event counters; frozen together with the pipe under ext_stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_retired <= 32'd0;
      perf_bubbles <= 32'd0;
    end else if (!ext_stall) begin
      if (retire) perf_retired <= perf_retired + 32'd1;
      if (redirect || load_use) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_tracker.sv
// Directed bench for pipe_tracker at default parameters (STAGES=4, LOAD_STAGE=2).
module tb_pipe_tracker;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BEQ = 32'h0000_0063;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [31:0]  in_instr;
  logic [24:0]  in_ctrl;
  logic         in_rwe;
  logic         in_ld;
  logic         redirect;
  logic         ext_stall;
  logic         stall;
  logic [3:0]   st_valid;
  logic [127:0] st_instr;
  logic [99:0]  st_ctrl;
  logic [3:0]   st_rwe;
  logic [1:0]   fw_sel1;
  logic [1:0]   fw_sel2;
  logic         retire;
`ifdef PIPE_TRACKER_PERF_EN
  logic [31:0]  perf_retired;
  logic [31:0]  perf_bubbles;
`endif

  int total = 0;
  int bad   = 0;

  pipe_tracker dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_ctrl   (in_ctrl),
    .in_rwe    (in_rwe),
    .in_ld     (in_ld),
    .redirect  (redirect),
    .ext_stall (ext_stall),
    .stall     (stall),
    .st_valid  (st_valid),
    .st_instr  (st_instr),
    .st_ctrl   (st_ctrl),
    .st_rwe    (st_rwe),
    .fw_sel1   (fw_sel1),
    .fw_sel2   (fw_sel2),
`ifdef PIPE_TRACKER_PERF_EN
    .perf_retired (perf_retired),
    .perf_bubbles (perf_bubbles),
`endif
    .retire    (retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'h03};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] ins, input logic rwe, input logic ld);
    in_valid = 1'b1;
    in_instr = ins;
    in_ctrl  = ins[31:7];
    in_rwe   = rwe;
    in_ld    = ld;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_instr = NOP;
    in_ctrl  = '0;
    in_rwe   = 1'b0;
    in_ld    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (5) step();
  endtask

  logic [31:0] a [6];
  logic [31:0] p [5];

  initial begin
    rst = 1'b0;
    redirect = 1'b0;
    ext_stall = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", 128'(st_valid), 128'(4'h0));
    chk("rst_instr0", 128'(st_instr[31:0]), 128'(NOP));
    chk("rst_ctrl", 128'(st_ctrl), 128'(0));
    chk("rst_stall", 128'(stall), 128'(0));
    chk("rst_retire", 128'(retire), 128'(0));
    chk("rst_fw", 128'({fw_sel1, fw_sel2}), 128'(0));
    rst = 1'b1;
    step();

    // Six independent adds back to back: retire pulses after edges 4..9.
    for (int i = 0; i < 6; i++) a[i] = r_type(5'(10 + i), 5'd1, 5'd2);
    for (int c = 1; c <= 10; c++) begin
      if (c <= 6) issue(a[c-1], 1'b1, 1'b0);
      else idle();
      step();
      chk($sformatf("seq_retire_c%0d", c), 128'(retire), 128'((c >= 4 && c <= 9) ? 1 : 0));
      chk($sformatf("seq_fw_c%0d", c), 128'({fw_sel1, fw_sel2}), 128'(0));
      if (c == 4) begin
        chk("seq_full", 128'(st_valid), 128'(4'hF));
        chk("seq_instr3", 128'(st_instr[127:96]), 128'(a[0]));
        chk("seq_ctrl3", 128'(st_ctrl[99:75]), 128'(a[0][31:7]));
        chk("seq_rwe", 128'(st_rwe), 128'(4'hF));
      end
    end

    // add x5 then sub x6,x5,x3 back to back: producer in stage 2.
    issue(r_type(5'd5, 5'd1, 5'd2), 1'b1, 1'b0); step();
    issue(r_type(5'd6, 5'd5, 5'd3), 1'b1, 1'b0); step();
    idle(); step();
    chk("fwd_adj_sel1", 128'(fw_sel1), 128'(2));
    chk("fwd_adj_sel2", 128'(fw_sel2), 128'(0));
    drain();

    // One-slot gap: producer in stage 3.
    issue(r_type(5'd5, 5'd1, 5'd2), 1'b1, 1'b0); step();
    idle(); step();
    issue(r_type(5'd6, 5'd5, 5'd3), 1'b1, 1'b0); step();
    idle(); step();
    chk("fwd_gap_sel1", 128'(fw_sel1), 128'(3));
    drain();

    // Two producers of x5: the younger (stage 2) wins on both operands.
    issue(r_type(5'd5, 5'd1, 5'd2), 1'b1, 1'b0); step();
    issue(r_type(5'd5, 5'd3, 5'd4), 1'b1, 1'b0); step();
    issue(r_type(5'd6, 5'd5, 5'd5), 1'b1, 1'b0); step();
    idle(); step();
    chk("fwd_young", 128'({fw_sel1, fw_sel2}), 128'({2'd2, 2'd2}));
    drain();

    // x0 destination never forwards.
    issue(r_type(5'd0, 5'd1, 5'd2), 1'b1, 1'b0); step();
    issue(r_type(5'd6, 5'd0, 5'd0), 1'b1, 1'b0); step();
    idle(); step();
    chk("fwd_x0", 128'({fw_sel1, fw_sel2}), 128'(0));
    drain();

    // lw x5 then add x6,x5,x5: one stall cycle, bubble in stage 1, then the
    // load (now one stage further on because of the bubble) forwards from stage 3.
    issue(lw(5'd5, 5'd1), 1'b1, 1'b1); step();
    chk("lu_pre_stall", 128'(stall), 128'(0));
    issue(r_type(5'd6, 5'd5, 5'd5), 1'b1, 1'b0); step();
    chk("lu_stall", 128'(stall), 128'(1));
    chk("lu_valid_a", 128'(st_valid), 128'(4'b0011));
    idle(); step();
    chk("lu_stall_off", 128'(stall), 128'(0));
    chk("lu_valid_b", 128'(st_valid), 128'(4'b0101));
    chk("lu_bub_ctrl", 128'(st_ctrl[49:25]), 128'(0));
    chk("lu_bub_instr", 128'(st_instr[63:32]), 128'(NOP));
    chk("lu_held", 128'(st_instr[31:0]), 128'(r_type(5'd6, 5'd5, 5'd5)));
    step();
    chk("lu_valid_c", 128'(st_valid), 128'(4'b1010));
    chk("lu_fw", 128'({fw_sel1, fw_sel2}), 128'({2'd3, 2'd3}));
    drain();

    // Load into x0 never stalls.
    issue(lw(5'd0, 5'd1), 1'b1, 1'b1); step();
    issue(r_type(5'd6, 5'd0, 5'd0), 1'b1, 1'b0); step();
    chk("lu_x0", 128'(stall), 128'(0));
    drain();

    // Redirect with a branch in stage 1.
    issue(BEQ, 1'b0, 1'b0); step();
    issue(r_type(5'd7, 5'd1, 5'd2), 1'b1, 1'b0); step();
    redirect = 1'b1;
    issue(r_type(5'd8, 5'd1, 5'd2), 1'b1, 1'b0);
    #1;
    chk("rd_stall", 128'(stall), 128'(0));
    step();
    redirect = 1'b0;
    chk("rd_valid", 128'(st_valid), 128'(4'b0100));
    chk("rd_branch", 128'(st_instr[95:64]), 128'(BEQ));
    chk("rd_bub1", 128'(st_instr[63:32]), 128'(NOP));
    drain();

    // Redirect overrides a simultaneous load-use stall.
    issue(lw(5'd5, 5'd1), 1'b1, 1'b1); step();
    issue(r_type(5'd6, 5'd5, 5'd5), 1'b1, 1'b0); step();
    chk("rdlu_pre", 128'(stall), 128'(1));
    redirect = 1'b1;
    #1;
    chk("rdlu_stall", 128'(stall), 128'(0));
    idle(); step();
    redirect = 1'b0;
    chk("rdlu_valid", 128'(st_valid), 128'(4'b0100));
    drain();

    // ext_stall for 3 cycles with a full pipe, then resume.
    for (int i = 0; i < 5; i++) p[i] = r_type(5'(20 + i), 5'd1, 5'd2);
    for (int i = 0; i < 4; i++) begin
      issue(p[i], 1'b1, 1'b0); step();
    end
    issue(p[4], 1'b1, 1'b0);
    ext_stall = 1'b1;
    #1;
    chk("es_retire0", 128'(retire), 128'(0));
    chk("es_stall0", 128'(stall), 128'(1));
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("es_instr_%0d", c), st_instr, {p[0], p[1], p[2], p[3]});
      chk($sformatf("es_valid_%0d", c), 128'(st_valid), 128'(4'hF));
      chk($sformatf("es_retire_%0d", c), 128'(retire), 128'(0));
    end
    ext_stall = 1'b0;
    #1;
    chk("es_resume_retire", 128'(retire), 128'(1));
    step();
    chk("es_resume_instr", st_instr, {p[1], p[2], p[3], p[4]});

    // Asynchronous reset mid-stream empties the pipe.
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(st_valid), 128'(0));
    chk("mid_rst_instr", st_instr, {NOP, NOP, NOP, NOP});
    rst = 1'b1;
    idle(); step();
    chk("mid_rst_after", 128'(st_valid), 128'(0));

`ifdef PIPE_TRACKER_PERF_EN
    // 10 retires, 2 redirects, plus one frozen redirect cycle that must not count.
    rst = 1'b0;
    #1;
    chk("perf_rst", 128'({perf_retired, perf_bubbles}), 128'(0));
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      issue(r_type(5'(10 + i), 5'd1, 5'd2), 1'b1, 1'b0); step();
    end
    drain();
    redirect = 1'b1;
    step(); step();
    ext_stall = 1'b1;
    step();
    ext_stall = 1'b0;
    redirect = 1'b0;
    step();
    chk("perf_retired", 128'(perf_retired), 128'(10));
    chk("perf_bubbles", 128'(perf_bubbles), 128'(2));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
